// File: rtl/tlb_pkg.sv
// ---------------------------------------------------------------------------
// tlb_pkg
// Shared definitions for the CP0 TLB operation controller and the TLB lookup
// paths: entry width, packed entry layout, field offsets, the CP0 operation
// encoding, the controller state encoding and CP0 <-> entry conversions.
// No ports (package).
// ---------------------------------------------------------------------------
package tlb_pkg;

    localparam int TLB_ENTRY_W = 78;

    // Bit offsets of each field inside a packed 78-bit entry (LSB = 0).
    localparam int OFF_V1   = 0;
    localparam int OFF_D1   = 1;
    localparam int OFF_C1   = 2;
    localparam int OFF_PFN1 = 5;
    localparam int OFF_V0   = 25;
    localparam int OFF_D0   = 26;
    localparam int OFF_C0   = 27;
    localparam int OFF_PFN0 = 30;
    localparam int OFF_G    = 50;
    localparam int OFF_ASID = 51;
    localparam int OFF_VPN2 = 59;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_TLBP  = 2'b01,
        OP_TLBR  = 2'b10,
        OP_TLBWI = 2'b11
    } tlb_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_READ,
        ST_READ_RSP,
        ST_WRITE,
        ST_DONE
    } tlb_state_e;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    // CP0 EntryHi/EntryLo0/EntryLo1 -> array entry. G is only global when
    // both halves say so, matching the MIPS TLBWI behaviour.
    function automatic tlb_entry_t pack_entry(input logic [31:0] hi,
                                              input logic [31:0] lo0,
                                              input logic [31:0] lo1);
        tlb_entry_t e;
        e.vpn2 = hi[31:13];
        e.asid = hi[7:0];
        e.g    = lo0[0] & lo1[0];
        e.pfn0 = lo0[25:6];
        e.c0   = lo0[5:3];
        e.d0   = lo0[2];
        e.v0   = lo0[1];
        e.pfn1 = lo1[25:6];
        e.c1   = lo1[5:3];
        e.d1   = lo1[2];
        e.v1   = lo1[1];
        return e;
    endfunction

    function automatic logic [31:0] unpack_hi(input tlb_entry_t e);
        return {e.vpn2, 5'b0, e.asid};
    endfunction

    function automatic logic [31:0] unpack_lo0(input tlb_entry_t e);
        return {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g};
    endfunction

    function automatic logic [31:0] unpack_lo1(input tlb_entry_t e);
        return {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g};
    endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl_if
// Bundles the CP0 request/response signals and the single-port TLB array
// port of tlb_op_ctrl.
//   master : CP0 side + array model (drives requests and tlb_rdata)
//   slave  : the controller (drives op_ready, done, results, array address,
//            write enable and write data)
// ---------------------------------------------------------------------------
interface tlb_op_ctrl_if
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
);
    localparam int IW = $clog2(TLB_ENTRIES);

    logic                   op_valid;
    logic                   op_ready;
    logic [1:0]             op_code;
    logic [IW-1:0]          index_i;
    logic [31:0]            entryhi_i;
    logic [31:0]            entrylo0_i;
    logic [31:0]            entrylo1_i;
    logic                   done;
    logic                   probe_miss;
    logic [IW-1:0]          probe_index;
    logic [31:0]            entryhi_o;
    logic [31:0]            entrylo0_o;
    logic [31:0]            entrylo1_o;
    logic                   flush_o;
    logic [IW-1:0]          tlb_addr;
    logic                   tlb_we;
    logic [TLB_ENTRY_W-1:0] tlb_wdata;
    logic [TLB_ENTRY_W-1:0] tlb_rdata;

    modport master (
        output op_valid, op_code, index_i, entryhi_i, entrylo0_i, entrylo1_i,
        output tlb_rdata,
        input  op_ready, done, probe_miss, probe_index,
        input  entryhi_o, entrylo0_o, entrylo1_o, flush_o,
        input  tlb_addr, tlb_we, tlb_wdata
    );

    modport slave (
        input  op_valid, op_code, index_i, entryhi_i, entrylo0_i, entrylo1_i,
        input  tlb_rdata,
        output op_ready, done, probe_miss, probe_index,
        output entryhi_o, entrylo0_o, entrylo1_o, flush_o,
        output tlb_addr, tlb_we, tlb_wdata
    );

endinterface

// File: rtl/tlb_entry_match.sv
// ---------------------------------------------------------------------------
// tlb_entry_match
// Combinational VPN2/ASID match of one TLB entry (4 KB pages, no PageMask).
//   entry : packed TLB entry
//   vpn2  : virtual page pair number to look up
//   asid  : current address space id
//   hit   : entry translates this vpn2 for this asid
// ---------------------------------------------------------------------------
module tlb_entry_match
    import tlb_pkg::*;
(
    input  tlb_entry_t  entry,
    input  logic [18:0] vpn2,
    input  logic [7:0]  asid,
    output logic        hit
);
    // Physical-side fields play no part in matching.
    logic w_unused_fields;
    assign w_unused_fields = ^{entry.pfn0, entry.c0, entry.d0, entry.v0,
                               entry.pfn1, entry.c1, entry.d1, entry.v1};

    assign hit = (entry.vpn2 == vpn2) && (entry.g || (entry.asid == asid));

endmodule

// File: rtl/tlb_op_ctrl.sv
// ---------------------------------------------------------------------------
// tlb_op_ctrl
// Sequences CP0 TLBP/TLBR/TLBWI (and NOP) against a single-port TLB array
// with one-cycle read latency.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : tlb_op_ctrl_if.slave -- request (op_valid/op_ready, op_code,
//              index_i, entryhi_i, entrylo*_i), completion (done, flush_o),
//              results (probe_*, entry*_o), array port (tlb_addr, tlb_we,
//              tlb_wdata, tlb_rdata)
// ---------------------------------------------------------------------------
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int TLB_ENTRIES = 16
) (
    input  logic         clk,
    input  logic         rst,
    tlb_op_ctrl_if.slave bus
);
    localparam int          IW         = $clog2(TLB_ENTRIES);
    localparam logic [IW:0] LP_CNT_END = (IW+1)'(TLB_ENTRIES);

    tlb_state_e    r_state, w_state_next;
    tlb_op_e       r_op;
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    tlb_entry_t    r_wentry;
    // Probe counter = address presented this cycle; one bit wider so the
    // final compare cycle (count == N) never wraps back to entry 0.
    logic [IW:0]   r_cnt, w_cnt_next;
    logic          r_probe_miss;
    logic [IW-1:0] r_probe_index;
    logic [31:0]   r_entryhi, r_entrylo0, r_entrylo1;

    logic          w_accept, w_hit;
    logic          w_probe_upd, w_probe_miss_next, w_read_upd;
    logic [IW-1:0] w_probe_index_next, w_cmp_index;
    tlb_entry_t    w_rentry;
    logic          w_unused_bits;

    assign w_unused_bits = ^{bus.entryhi_i[12:8], bus.entrylo0_i[31:26],
                             bus.entrylo1_i[31:26]};

    assign w_rentry = tlb_entry_t'(bus.tlb_rdata);
    assign w_accept = (r_state == ST_IDLE) && bus.op_valid;
    // tlb_rdata holds the entry addressed last cycle, i.e. r_cnt - 1.
    assign w_cmp_index = r_cnt[IW-1:0] - IW'(1);

    tlb_entry_match u_match (
        .entry (w_rentry),
        .vpn2  (r_vpn2),
        .asid  (r_asid),
        .hit   (w_hit)
    );

    always_comb begin
        w_state_next       = r_state;
        w_cnt_next         = r_cnt;
        w_probe_upd        = 1'b0;
        w_probe_miss_next  = r_probe_miss;
        w_probe_index_next = r_probe_index;
        w_read_upd         = 1'b0;
        bus.op_ready       = 1'b0;
        bus.done           = 1'b0;
        bus.flush_o        = 1'b0;
        bus.tlb_addr       = '0;
        bus.tlb_we         = 1'b0;
        bus.tlb_wdata      = '0;
        case (r_state)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
                if (bus.op_valid) begin
                    case (tlb_op_e'(bus.op_code))
                        OP_TLBP:  begin
                            w_state_next = ST_PROBE;
                            w_cnt_next   = '0;
                        end
                        OP_TLBR:  w_state_next = ST_READ;
                        OP_TLBWI: w_state_next = ST_WRITE;
                        default:  w_state_next = ST_DONE;
                    endcase
                end
            end
            ST_PROBE: begin
                if (r_cnt != LP_CNT_END) begin
                    bus.tlb_addr = r_cnt[IW-1:0];
                end
                if ((r_cnt != '0) && w_hit) begin
                    w_state_next       = ST_DONE;
                    w_probe_upd        = 1'b1;
                    w_probe_miss_next  = 1'b0;
                    w_probe_index_next = w_cmp_index;
                end else if (r_cnt == LP_CNT_END) begin
                    w_state_next      = ST_DONE;
                    w_probe_upd       = 1'b1;
                    w_probe_miss_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_READ: begin
                bus.tlb_addr = r_index;
                w_state_next = ST_READ_RSP;
            end
            ST_READ_RSP: begin
                w_read_upd   = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_WRITE: begin
                bus.tlb_addr  = r_index;
                bus.tlb_we    = 1'b1;
                bus.tlb_wdata = r_wentry;
                w_state_next  = ST_DONE;
            end
            ST_DONE: begin
                bus.done     = 1'b1;
                bus.flush_o  = (r_op == OP_TLBWI);
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_op          <= OP_NOP;
            r_index       <= '0;
            r_vpn2        <= '0;
            r_asid        <= '0;
            r_wentry      <= '0;
            r_cnt         <= '0;
            r_probe_miss  <= 1'b0;
            r_probe_index <= '0;
            r_entryhi     <= '0;
            r_entrylo0    <= '0;
            r_entrylo1    <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_op     <= tlb_op_e'(bus.op_code);
                r_index  <= bus.index_i;
                r_vpn2   <= bus.entryhi_i[31:13];
                r_asid   <= bus.entryhi_i[7:0];
                r_wentry <= pack_entry(bus.entryhi_i, bus.entrylo0_i, bus.entrylo1_i);
            end
            if (w_probe_upd) begin
                r_probe_miss  <= w_probe_miss_next;
                r_probe_index <= w_probe_index_next;
            end
            if (w_read_upd) begin
                r_entryhi  <= unpack_hi(w_rentry);
                r_entrylo0 <= unpack_lo0(w_rentry);
                r_entrylo1 <= unpack_lo1(w_rentry);
            end
        end
    end

    assign bus.probe_miss  = r_probe_miss;
    assign bus.probe_index = r_probe_index;
    assign bus.entryhi_o   = r_entryhi;
    assign bus.entrylo0_o  = r_entrylo0;
    assign bus.entrylo1_o  = r_entrylo1;

endmodule
